// File: rtl/readreq_arbiter_if.sv
// Bus bundle between the read-request arbiter and its peripherals / TX / RX units.
// master: arbiter side; slave: peripheral and control side.
interface readreq_arbiter_if #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned LEN_BYTES = 2
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]         read_req;
  logic [NCH-1:0]         n_read;
  logic [NCH*8-1:0]       data;
  logic [NCH-1:0]         n_wait;
  logic                   interrupt;
  logic                   txbusy;
  logic                   rxbusy;
  logic                   endtx;
  logic [LEN_BYTES*8-1:0] ndata;
  logic [CHW-1:0]         chan;
  logic                   runtx;
  logic                   busyreadreq;
  logic                   rd_timeout;
  logic [NCH-1:0]         pending;

  modport master (
    input  read_req, data, n_wait, interrupt, txbusy, rxbusy, endtx,
    output n_read, ndata, chan, runtx, busyreadreq, rd_timeout, pending
  );

  modport slave (
    output read_req, data, n_wait, interrupt, txbusy, rxbusy, endtx,
    input  n_read, ndata, chan, runtx, busyreadreq, rd_timeout, pending
  );
endinterface

// File: rtl/readreq_arbiter.sv
// Round-robin read-request arbiter: reads a multi-byte length from the granted channel
// over its n_read/n_wait handshake, then holds runtx until endtx.
module readreq_arbiter #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned LEN_BYTES = 2,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  readreq_arbiter_if.master io_bus
);
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IW  = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {StIdle, StSel, StRd, StGap, StRunTx} state_e;

  state_e                 r_state;
  logic [NCH-1:0]         r_read_req;
  logic [NCH-1:0]         r_pending;
  logic [NCH-1:0]         r_n_read;
  logic [LEN_BYTES*8-1:0] r_ndata;
  logic [CHW-1:0]         r_chan;
  logic [CHW-1:0]         r_ptr;
  logic [IW-1:0]          r_idx;
  logic [TW-1:0]          r_wait;
  logic                   r_runtx;
  logic                   r_busy;
  logic                   r_rd_timeout;

  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_chan_mask;
  logic [CHW-1:0] w_sel;
  logic           w_found;
  int             w_cand;
  logic [7:0]     w_byte;
  logic           w_nwait;
  logic           w_last;
  logic [TW:0]    w_wait_inc;
  logic           w_timeout;

  assign w_rise      = io_bus.read_req & ~r_read_req;
  assign w_chan_mask = NCH'(1) << r_chan;
  assign w_byte      = io_bus.data[r_chan*8 +: 8];
  assign w_nwait     = io_bus.n_wait[r_chan];
  assign w_last      = (r_idx == IW'(LEN_BYTES - 1));
  assign w_wait_inc  = {1'b0, r_wait} + (TW+1)'(1);
  assign w_timeout   = (TIMEOUT != 0) && (w_wait_inc == (TW+1)'(TIMEOUT));

  // First pending channel after the pointer, wrapping modulo NCH.
  always_comb begin
    w_sel   = r_ptr;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 1; i <= int'(NCH); i++) begin
      w_cand = (int'(r_ptr) + i) % int'(NCH);
      if (!w_found && r_pending[w_cand]) begin
        w_found = 1'b1;
        w_sel   = CHW'(w_cand);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == StRd && ((w_nwait && w_last) || (!w_nwait && w_timeout))) begin
      w_clr = w_chan_mask;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_read_req   <= '1;
      r_pending    <= '0;
      r_n_read     <= '1;
      r_ndata      <= '0;
      r_chan       <= '0;
      r_ptr        <= CHW'(NCH - 1);
      r_idx        <= '0;
      r_wait       <= '0;
      r_runtx      <= 1'b0;
      r_busy       <= 1'b0;
      r_rd_timeout <= 1'b0;
    end else begin
      r_read_req   <= io_bus.read_req;
      // A new edge on the channel being cleared keeps the request.
      r_pending    <= (r_pending & ~w_clr) | w_rise;
      r_rd_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if ((|r_pending) && !io_bus.rxbusy && !io_bus.txbusy && !io_bus.interrupt) begin
            r_state <= StSel;
            r_busy  <= 1'b1;
          end
        end
        StSel: begin
          r_chan   <= w_sel;
          r_ptr    <= w_sel;
          r_idx    <= '0;
          r_wait   <= '0;
          r_n_read <= ~(NCH'(1) << w_sel);
          r_state  <= StRd;
        end
        StRd: begin
          if (w_nwait) begin
            r_ndata[r_idx*8 +: 8] <= w_byte;
            r_n_read              <= '1;
            r_wait                <= '0;
            if (w_last) begin
              r_runtx <= 1'b1;
              r_state <= StRunTx;
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_state <= StGap;
            end
          end else if (w_timeout) begin
            r_n_read     <= '1;
            r_busy       <= 1'b0;
            r_rd_timeout <= 1'b1;
            r_state      <= StIdle;
          end else begin
            r_wait <= w_wait_inc[TW-1:0];
          end
        end
        StGap: begin
          r_wait   <= '0;
          r_n_read <= ~w_chan_mask;
          r_state  <= StRd;
        end
        StRunTx: begin
          if (io_bus.endtx) begin
            r_runtx <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.n_read      = r_n_read;
  assign io_bus.ndata       = r_ndata;
  assign io_bus.chan        = r_chan;
  assign io_bus.runtx       = r_runtx;
  assign io_bus.busyreadreq = r_busy;
  assign io_bus.rd_timeout  = r_rd_timeout;
  assign io_bus.pending     = r_pending;
endmodule

// File: tb/tb_readreq_arbiter.sv
// Self-checking bench for readreq_arbiter (NCH=4, LEN_BYTES=2, TIMEOUT=16) with a
// peripheral emulator and a round-robin reference model.
module tb_readreq_arbiter;
  localparam int NCH = 4;
  localparam int LEN = 2;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  logic [7:0]  tbl [NCH][LEN];
  int          m_ptr;
  logic [3:0]  m_pending;
  logic [15:0] m_ndata;

  readreq_arbiter_if #(.NCH(NCH), .LEN_BYTES(LEN)) rif ();

  readreq_arbiter #(.NCH(NCH), .LEN_BYTES(LEN), .TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (rif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next(input logic [3:0] p, input int ptr);
    for (int i = 1; i <= NCH; i++) begin
      if (p[(ptr + i) % NCH]) return (ptr + i) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_len(input int ch);
    return {tbl[ch][1], tbl[ch][0]};
  endfunction

  task automatic rand_tbl();
    for (int c = 0; c < NCH; c++)
      for (int i = 0; i < LEN; i++) tbl[c][i] = 8'($urandom);
  endtask

  // Peripheral emulator: answers the active n_read with table bytes after `waits` stall cycles
  // per byte; stops when runtx or rd_timeout appears, or after a 200-cycle budget.
  task automatic drive_xfer(input int waits, output int ch_obs, output int cycles,
                            output int first_low, output bit to_seen, output bit multi_low);
    int  k;
    int  wc;
    bit  cap;
    k = 0; wc = 0;
    ch_obs = -1; cycles = -1; first_low = 0; to_seen = 1'b0; multi_low = 1'b0;
    for (int t = 1; t <= 200; t++) begin
      cap = 1'b0;
      if (!$onehot0(~rif.n_read)) multi_low = 1'b1;
      if (rif.n_read != '1) begin
        for (int c = 0; c < NCH; c++) if (!rif.n_read[c]) ch_obs = c;
        for (int j = 0; j < NCH; j++) rif.data[j*8 +: 8] = tbl[j][(k < LEN) ? k : 0];
        if (k == 0) first_low++;
        if (wc < waits) begin
          rif.n_wait = '0;
          wc++;
        end else begin
          rif.n_wait = '1;
          cap = 1'b1;
        end
      end else begin
        rif.n_wait = '0;
      end
      tick();
      if (cap) begin
        k++;
        wc = 0;
      end
      if (rif.runtx || rif.rd_timeout) begin
        cycles  = t;
        to_seen = rif.rd_timeout;
        break;
      end
    end
    rif.n_wait = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (rif.n_read !== 4'hF) begin errs++; $display("FAIL reset_n_read got=%h exp=f", rif.n_read); end
    checks++; if (rif.ndata !== 16'h0) begin errs++; $display("FAIL reset_ndata got=%h exp=0", rif.ndata); end
    checks++; if (rif.chan !== 2'd0) begin errs++; $display("FAIL reset_chan got=%0d exp=0", rif.chan); end
    checks++; if (rif.runtx !== 1'b0) begin errs++; $display("FAIL reset_runtx got=%b exp=0", rif.runtx); end
    checks++; if (rif.busyreadreq !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", rif.busyreadreq); end
    checks++; if (rif.rd_timeout !== 1'b0) begin errs++; $display("FAIL reset_tmo got=%b exp=0", rif.rd_timeout); end
    checks++; if (rif.pending !== 4'h0) begin errs++; $display("FAIL reset_pending got=%h exp=0", rif.pending); end
    reset = 1'b0;
    tick();
    m_ptr = NCH - 1; m_pending = '0; m_ndata = '0;
  endtask

  task automatic test_single();
    int ch, cyc, fl; bit to, ml;
    rand_tbl();
    tbl[2][0] = 8'h34; tbl[2][1] = 8'h12;
    rif.read_req = 4'b0100;
    tick();
    m_pending = 4'b0100;
    checks++; if (rif.pending !== m_pending) begin errs++; $display("FAIL single_pending got=%h exp=%h", rif.pending, m_pending); end
    drive_xfer(0, ch, cyc, fl, to, ml);
    m_ptr = 2; m_pending = '0; m_ndata = 16'h1234;
    checks++; if (cyc !== 2*LEN+1) begin errs++; $display("FAIL single_latency got=%0d exp=%0d", cyc, 2*LEN+1); end
    checks++; if (ch !== 2) begin errs++; $display("FAIL single_nread_ch got=%0d exp=2", ch); end
    checks++; if (rif.chan !== 2'd2) begin errs++; $display("FAIL single_chan got=%0d exp=2", rif.chan); end
    checks++; if (rif.ndata !== 16'h1234) begin errs++; $display("FAIL single_ndata got=%h exp=1234", rif.ndata); end
    checks++; if (rif.busyreadreq !== 1'b1 || rif.n_read !== 4'hF) begin
      errs++; $display("FAIL single_runtx_state got busy=%b n_read=%h exp busy=1 n_read=f", rif.busyreadreq, rif.n_read);
    end
    checks++; if (rif.pending !== 4'h0) begin errs++; $display("FAIL single_pending_clr got=%h exp=0", rif.pending); end
    rif.read_req = '0;
    tick();
    checks++; if (rif.runtx !== 1'b1) begin errs++; $display("FAIL single_runtx_hold got=%b exp=1", rif.runtx); end
    rif.endtx = 1'b1;
    tick();
    rif.endtx = 1'b0;
    checks++; if (rif.runtx !== 1'b0 || rif.busyreadreq !== 1'b0) begin
      errs++; $display("FAIL single_endtx got runtx=%b busy=%b exp 0 0", rif.runtx, rif.busyreadreq);
    end
  endtask

  task automatic test_round_robin();
    int ch, cyc, fl, exp_ch; bit to, ml;
    reset = 1'b1; tick(); reset = 1'b0; tick();
    m_ptr = NCH - 1;
    rif.read_req = 4'b1011;
    tick();
    m_pending = 4'b1011;
    checks++; if (rif.pending !== m_pending) begin errs++; $display("FAIL rr_pending got=%h exp=%h", rif.pending, m_pending); end
    for (int n = 0; n < 3; n++) begin
      rand_tbl();
      exp_ch = model_next(m_pending, m_ptr);
      drive_xfer(0, ch, cyc, fl, to, ml);
      m_ptr = exp_ch; m_pending[exp_ch] = 1'b0; m_ndata = model_len(exp_ch);
      checks++; if (ch !== exp_ch || rif.chan !== 2'(exp_ch)) begin
        errs++; $display("FAIL rr_order[%0d] got nread_ch=%0d chan=%0d exp=%0d", n, ch, rif.chan, exp_ch);
      end
      checks++; if (rif.ndata !== m_ndata) begin errs++; $display("FAIL rr_ndata[%0d] got=%h exp=%h", n, rif.ndata, m_ndata); end
      checks++; if (rif.pending !== m_pending) begin errs++; $display("FAIL rr_pending[%0d] got=%h exp=%h", n, rif.pending, m_pending); end
      checks++; if (cyc !== 2*LEN+1) begin errs++; $display("FAIL rr_latency[%0d] got=%0d exp=%0d", n, cyc, 2*LEN+1); end
      rif.endtx = 1'b1; tick(); rif.endtx = 1'b0;
    end
    rif.read_req = '0;
    tick();
  endtask

  task automatic test_gating();
    int ch, cyc, fl, g; bit to, ml, quiet;
    g = $urandom_range(0, 2);
    rif.txbusy = (g == 0); rif.rxbusy = (g == 1); rif.interrupt = (g == 2);
    rif.read_req = 4'b0010;
    tick();
    m_pending = 4'b0010;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rif.n_read !== 4'hF || rif.busyreadreq !== 1'b0) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errs++; $display("FAIL gate_quiet gate=%0d got activity exp none", g); end
    checks++; if (rif.pending !== m_pending) begin errs++; $display("FAIL gate_pending got=%h exp=%h", rif.pending, m_pending); end
    rif.txbusy = 1'b0; rif.rxbusy = 1'b0; rif.interrupt = 1'b0;
    rand_tbl();
    drive_xfer(0, ch, cyc, fl, to, ml);
    m_ptr = 1; m_pending = '0; m_ndata = model_len(1);
    checks++; if (cyc !== 2*LEN+1 || ch !== 1) begin
      errs++; $display("FAIL gate_release got cyc=%0d ch=%0d exp cyc=%0d ch=1", cyc, ch, 2*LEN+1);
    end
    checks++; if (rif.ndata !== m_ndata) begin errs++; $display("FAIL gate_ndata got=%h exp=%h", rif.ndata, m_ndata); end
    rif.read_req = '0;
    rif.endtx = 1'b1; tick(); rif.endtx = 1'b0;
  endtask

  task automatic test_wait_states();
    int ch, cyc, fl; bit to, ml;
    rand_tbl();
    rif.read_req = 4'b0001;
    tick();
    drive_xfer(7, ch, cyc, fl, to, ml);
    m_ptr = 0; m_ndata = model_len(0);
    checks++; if (fl !== 8) begin errs++; $display("FAIL wait_low_cycles got=%0d exp=8", fl); end
    checks++; if (cyc !== 2*LEN+1+LEN*7) begin errs++; $display("FAIL wait_latency got=%0d exp=%0d", cyc, 2*LEN+1+LEN*7); end
    checks++; if (to !== 1'b0 || rif.runtx !== 1'b1) begin errs++; $display("FAIL wait_no_timeout got to=%b runtx=%b exp 0 1", to, rif.runtx); end
    checks++; if (rif.ndata !== m_ndata) begin errs++; $display("FAIL wait_ndata got=%h exp=%h", rif.ndata, m_ndata); end
    rif.read_req = '0;
    rif.endtx = 1'b1; tick(); rif.endtx = 1'b0;
  endtask

  task automatic test_timeout();
    int ch, cyc, fl; bit to, ml;
    rand_tbl();
    rif.read_req = 4'b1000;
    tick();
    drive_xfer(1000, ch, cyc, fl, to, ml);
    m_ptr = 3;
    checks++; if (to !== 1'b1 || cyc !== TMO+2) begin
      errs++; $display("FAIL tmo_pulse got to=%b cyc=%0d exp to=1 cyc=%0d", to, cyc, TMO+2);
    end
    checks++; if (rif.runtx !== 1'b0) begin errs++; $display("FAIL tmo_runtx got=%b exp=0", rif.runtx); end
    tick();
    checks++; if (rif.rd_timeout !== 1'b0) begin errs++; $display("FAIL tmo_single got=%b exp=0", rif.rd_timeout); end
    checks++; if (rif.pending !== 4'h0 || rif.busyreadreq !== 1'b0 || rif.n_read !== 4'hF) begin
      errs++; $display("FAIL tmo_idle got pend=%h busy=%b n_read=%h exp 0 0 f", rif.pending, rif.busyreadreq, rif.n_read);
    end
    checks++; if (rif.ndata !== m_ndata) begin errs++; $display("FAIL tmo_ndata got=%h exp=%h", rif.ndata, m_ndata); end
    rif.read_req = '0;
    tick();
  endtask

  task automatic test_random();
    int ch, cyc, fl, w, exp_ch, hold; bit to, ml;
    for (int it = 0; it < 6; it++) begin
      rif.read_req = '0;
      tick();
      rif.read_req = 4'($urandom_range(1, 15));
      m_pending = rif.read_req;
      tick();
      while (m_pending != 0) begin
        rand_tbl();
        w = $urandom_range(0, 4);
        exp_ch = model_next(m_pending, m_ptr);
        drive_xfer(w, ch, cyc, fl, to, ml);
        m_ptr = exp_ch; m_pending[exp_ch] = 1'b0; m_ndata = model_len(exp_ch);
        checks++; if (ch !== exp_ch || rif.chan !== 2'(exp_ch) || ml !== 1'b0) begin
          errs++; $display("FAIL rand_chan[%0d] got ch=%0d chan=%0d multi=%b exp=%0d", it, ch, rif.chan, ml, exp_ch);
        end
        checks++; if (rif.ndata !== m_ndata || rif.pending !== m_pending) begin
          errs++; $display("FAIL rand_data[%0d] got nd=%h pend=%h exp nd=%h pend=%h", it, rif.ndata, rif.pending, m_ndata, m_pending);
        end
        checks++; if (cyc !== 2*LEN+1+LEN*w) begin errs++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", it, cyc, 2*LEN+1+LEN*w); end
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) tick();
        rif.endtx = 1'b1; tick(); rif.endtx = 1'b0;
        checks++; if (rif.runtx !== 1'b0) begin errs++; $display("FAIL rand_endtx[%0d] got=%b exp=0", it, rif.runtx); end
      end
    end
    rif.read_req = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit quiet;
    rif.read_req = 4'b0010;
    tick(); tick(); tick();
    rif.data = {NCH{8'hA5}};
    rif.n_wait = '1;
    tick();
    rif.n_wait = '0;
    checks++; if (rif.busyreadreq !== 1'b1 || rif.n_read !== 4'hF) begin
      errs++; $display("FAIL mid_gap got busy=%b n_read=%h exp 1 f", rif.busyreadreq, rif.n_read);
    end
    reset = 1'b1;
    tick();
    checks++; if (rif.n_read !== 4'hF || rif.ndata !== 16'h0 || rif.chan !== 2'd0 || rif.runtx !== 1'b0 ||
                  rif.busyreadreq !== 1'b0 || rif.rd_timeout !== 1'b0 || rif.pending !== 4'h0) begin
      errs++; $display("FAIL mid_reset got n_read=%h nd=%h chan=%0d runtx=%b busy=%b tmo=%b pend=%h exp f 0 0 0 0 0 0",
                       rif.n_read, rif.ndata, rif.chan, rif.runtx, rif.busyreadreq, rif.rd_timeout, rif.pending);
    end
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rif.pending !== 4'h0 || rif.busyreadreq !== 1'b0 || rif.n_read !== 4'hF) quiet = 1'b0;
    end
    checks++; if (quiet !== 1'b1) begin errs++; $display("FAIL mid_no_retrigger got activity exp none"); end
    rif.read_req = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    rif.read_req = '0; rif.data = '0; rif.n_wait = '0;
    rif.interrupt = 1'b0; rif.txbusy = 1'b0; rif.rxbusy = 1'b0; rif.endtx = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_gating();
    test_wait_states();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
